// File: rtl/fifo_arb_pkg.sv
// Shared types for the FIFO write arbiter: FSM state encoding and beat counter width.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fifo_arb_pkg;

    // Wide enough to count beats for bursts of up to 16.
    localparam int BEAT_W = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin picker: first asserted request after index 'last', wrapping modulo NREQ.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the pick is used.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDXW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] last,
    output logic [NREQ-1:0] oh,
    output logic [IDXW-1:0] idx
);

    int              cand;
    logic [IDXW-1:0] cand_idx;
    logic            found;

    // Scan from last+1 around the ring; the first hit wins.
    always_comb begin
        oh       = '0;
        idx      = '0;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int off = 1; off <= NREQ; off++) begin
            cand     = (int'(last) + off) % NREQ;
            cand_idx = IDXW'(cand);
            if (!found && req[cand_idx]) begin
                found         = 1'b1;
                idx           = cand_idx;
                oh[cand_idx]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Bursting round-robin arbiter feeding N write requesters into one FIFO write port.
// Latency: grant one cycle after the IDLE decision; beats pass through combinationally.
// Backpressure: wfull stalls the granted requester; almost_full only blocks new grants.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int DW        = 32,
    parameter int BURST_MAX = 8
) (
    input  logic               wclk,
    input  logic               wrst_n,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    input  logic               wfull,
    input  logic               almost_full,
    output logic [DW-1:0]      wdata,
    output logic               winc,
    output logic [NREQ-1:0]    gnt,
    output logic               busy
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_t        state;
    logic [NREQ-1:0]   gnt_q;
    logic [IDXW-1:0]   gidx;
    logic [IDXW-1:0]   last_gnt;
    logic [BEAT_W-1:0] beat_cnt;

    logic [NREQ-1:0]   pick_oh;
    logic [IDXW-1:0]   pick_idx;
    logic              in_burst;
    logic              start;
    logic              last_beat;

    rr_pick #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_pick (
        .req  (req_valid),
        .last (last_gnt),
        .oh   (pick_oh),
        .idx  (pick_idx)
    );

    assign in_burst  = (state == BURST);
    assign start     = (|req_valid) && !wfull && !almost_full;
    assign last_beat = (beat_cnt == BEAT_W'(BURST_MAX - 1));
    assign gnt       = gnt_q;
    assign busy      = in_burst;

    // Ready goes only to the granted requester and tracks wfull alone, never req_valid.
    always_comb begin
        req_ready = '0;
        wdata     = '0;
        if (in_burst) begin
            req_ready[gidx] = ~wfull;
            wdata           = req_data[int'(gidx)*DW +: DW];
        end
    end

    assign winc = req_valid[gidx] & req_ready[gidx];

    // Grant FSM: pick in IDLE, stream beats in BURST, always fall back through IDLE.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state    <= IDLE;
            gnt_q    <= '0;
            gidx     <= '0;
            beat_cnt <= '0;
            last_gnt <= IDXW'(NREQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        gnt_q    <= pick_oh;
                        gidx     <= pick_idx;
                        beat_cnt <= '0;
                        state    <= BURST;
                    end
                end
                BURST: begin
                    // A dropped valid forfeits the rest of the burst.
                    if (!req_valid[gidx] || (winc && last_beat)) begin
                        state    <= IDLE;
                        gnt_q    <= '0;
                        last_gnt <= gidx;
                    end else if (winc) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: requester queues driven from tables, outputs checked per cycle.
// Latency: inputs applied 2 time units after posedge, outputs sampled 2 units later.
// Backpressure: wfull/almost_full driven explicitly per scenario.
module tb_fifo_wr_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 32;

    logic               wclk;
    logic               wrst_n;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic               wfull;
    logic               almost_full;
    logic [DW-1:0]      wdata;
    logic               winc;
    logic [NREQ-1:0]    gnt;
    logic               busy;

    logic [NREQ-1:0] en;
    int cnt  [NREQ];
    int len  [NREQ];
    int base [NREQ];

    int n_assert;
    int n_fail;

    fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .BURST_MAX(8)) dut (
        .wclk        (wclk),
        .wrst_n      (wrst_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .wfull       (wfull),
        .almost_full (almost_full),
        .wdata       (wdata),
        .winc        (winc),
        .gnt         (gnt),
        .busy        (busy)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_assert++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]           = en[i] && (cnt[i] < len[i]);
            req_data[i*DW +: DW]   = DW'(base[i] + cnt[i]);
        end
    endtask

    task automatic settle();
        drive_reqs();
        #2;
    endtask

    // Advance one clock; requesters whose beat was accepted move to their next word.
    task automatic adv();
        logic [NREQ-1:0] pop;
        pop = req_valid & req_ready;
        @(posedge wclk);
        #2;
        for (int i = 0; i < NREQ; i++)
            if (pop[i]) cnt[i]++;
        drive_reqs();
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk_eq({tag, "_gnt"},   gnt,       '0);
        chk_eq({tag, "_busy"},  busy,      '0);
        chk_eq({tag, "_winc"},  winc,      '0);
        chk_eq({tag, "_ready"}, req_ready, '0);
        chk_eq({tag, "_wdata"}, wdata,     '0);
    endtask

    task automatic do_reset();
        wrst_n      = 1'b0;
        en          = '0;
        wfull       = 1'b0;
        almost_full = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            cnt[i]  = 0;
            len[i]  = 0;
            base[i] = 0;
        end
        settle();
        chk_idle_outputs("rst");
        adv();
        wrst_n = 1'b1;
    endtask

    initial begin
        int k;
        int b;
        int r;
        logic       exp_w;
        logic       exp_b;
        logic [3:0] exp_g;
        logic [3:0] s5_gnt  [8];
        logic       s5_winc [8];
        int         s5_data [8];

        n_assert    = 0;
        n_fail      = 0;
        wrst_n      = 1'b0;
        wfull       = 1'b0;
        almost_full = 1'b0;
        req_valid   = '0;
        req_data    = '0;
        en          = '0;
        @(posedge wclk);
        #2;

        // Single requester, 20 words: bursts of 8, 8, 4 with one bubble between.
        do_reset();
        en = 4'b0010; len[1] = 20; base[1] = 32'h100;
        k = 0;
        for (int c = 0; c <= 24; c++) begin
            settle();
            exp_w = (c >= 1 && c <= 8) || (c >= 10 && c <= 17) || (c >= 19 && c <= 22);
            exp_b = (c >= 1 && c <= 8) || (c >= 10 && c <= 17) || (c >= 19 && c <= 23);
            chk_eq($sformatf("s1_winc_c%0d", c), winc, exp_w);
            chk_eq($sformatf("s1_busy_c%0d", c), busy, exp_b);
            if (exp_w) begin
                chk_eq($sformatf("s1_data_c%0d", c), wdata, 64'h100 + k);
                chk_eq($sformatf("s1_gnt_c%0d", c), gnt, 4'b0010);
                k++;
            end
            adv();
        end

        // All four requesters continuously valid: 0,1,2,3,0 with 8 beats each.
        do_reset();
        en = 4'b1111;
        for (int i = 0; i < NREQ; i++) begin
            len[i]  = 1000;
            base[i] = i * 256;
        end
        for (int c = 0; c <= 44; c++) begin
            settle();
            if (c % 9 == 0) begin
                chk_eq($sformatf("s2_gnt_c%0d", c), gnt, 4'b0000);
                chk_eq($sformatf("s2_winc_c%0d", c), winc, 1'b0);
            end else begin
                b = c / 9;
                r = b % 4;
                k = c % 9 - 1;
                exp_g = 4'b0001 << r;
                chk_eq($sformatf("s2_gnt_c%0d", c), gnt, exp_g);
                chk_eq($sformatf("s2_winc_c%0d", c), winc, 1'b1);
                chk_eq($sformatf("s2_data_c%0d", c), wdata, r * 256 + (b / 4) * 8 + k);
            end
            adv();
        end

        // wfull held for 5 cycles at beat 3: stall, then resume to a full 8 beats.
        do_reset();
        en = 4'b0001; len[0] = 20; base[0] = 32'h600;
        k = 0;
        for (int c = 0; c <= 14; c++) begin
            wfull = (c >= 4 && c <= 8);
            settle();
            exp_w = (c >= 1 && c <= 3) || (c >= 9 && c <= 13);
            chk_eq($sformatf("s3_winc_c%0d", c), winc, exp_w);
            chk_eq($sformatf("s3_ready_c%0d", c), req_ready,
                   (c >= 1 && c <= 13 && !wfull) ? 4'b0001 : 4'b0000);
            if (exp_w) begin
                chk_eq($sformatf("s3_data_c%0d", c), wdata, 64'h600 + k);
                k++;
            end
            adv();
        end
        chk_eq("s3_total_beats", k, 8);
        wfull = 1'b0;

        // almost_full blocks new grants; grant to requester 2 the cycle after it drops.
        do_reset();
        len[2] = 5; base[2] = 32'h200;
        for (int c = 0; c <= 6; c++) begin
            almost_full = (c < 4);
            en = (c >= 2) ? 4'b0100 : 4'b0000;
            settle();
            chk_eq($sformatf("s4_gnt_c%0d", c), gnt, (c >= 5) ? 4'b0100 : 4'b0000);
            chk_eq($sformatf("s4_busy_c%0d", c), busy, c >= 5);
            if (c >= 5)
                chk_eq($sformatf("s4_data_c%0d", c), wdata, 64'h200 + (c - 5));
            adv();
        end
        almost_full = 1'b0;

        // Requester 1 runs dry after 3 beats; round-robin moves on to 2 ahead of 0.
        do_reset();
        s5_gnt  = '{4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0100, 4'b0100};
        s5_winc = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        s5_data = '{0, 'h300, 'h301, 'h302, 0, 0, 'h400, 'h401};
        len[1] = 3;  base[1] = 32'h300;
        len[2] = 10; base[2] = 32'h400;
        len[0] = 10; base[0] = 32'h500;
        for (int c = 0; c <= 7; c++) begin
            en = (c >= 3) ? 4'b0111 : 4'b0110;
            settle();
            chk_eq($sformatf("s5_gnt_c%0d", c), gnt, s5_gnt[c]);
            chk_eq($sformatf("s5_winc_c%0d", c), winc, s5_winc[c]);
            if (s5_winc[c])
                chk_eq($sformatf("s5_data_c%0d", c), wdata, s5_data[c]);
            if (c == 4) begin
                chk_eq("s5_busy_drop", busy, 1'b1);
                chk_eq("s5_ready_drop", req_ready, 4'b0010);
            end
            adv();
        end

        // Reset pulse mid-burst of requester 3; arbitration restarts at requester 0.
        do_reset();
        en = 4'b1111;
        for (int i = 0; i < NREQ; i++) begin
            len[i]  = 1000;
            base[i] = i * 256;
        end
        for (int c = 0; c <= 29; c++) begin
            settle();
            if (c == 29) begin
                chk_eq("s6_gnt_pre", gnt, 4'b1000);
                chk_eq("s6_winc_pre", winc, 1'b1);
            end
            adv();
        end
        wrst_n = 1'b0;
        settle();
        chk_idle_outputs("s6_rst0");
        adv();
        settle();
        chk_idle_outputs("s6_rst1");
        adv();
        wrst_n = 1'b1;
        settle();
        chk_eq("s6_gnt_rel", gnt, 4'b0000);
        adv();
        settle();
        chk_eq("s6_gnt_first", gnt, 4'b0001);
        chk_eq("s6_winc_first", winc, 1'b1);
        chk_eq("s6_data_first", wdata, 64'd8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
